// File: rtl/clk_ratio_pkg.sv
// Shared definitions for the clock-ratio controller and its timer.
// Holds the FSM state encoding, the default ratio bus width shared with
// the clock divider, and a small constant helper used for sizing.
package clk_ratio_pkg;

    // Ratio bus width shared with the downstream clock divider.
    localparam int unsigned RATIO_WD_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOAD   = 2'd2,
        ST_SETTLE = 2'd3
    } ratio_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_ratio_timer.sv
// Loadable up-counter with a terminal-count flag.
// Shared by the DRAIN and SETTLE phases of the ratio controller. The
// controller stops incrementing once the terminal count is reached, so the
// counter never wraps.
module clk_ratio_timer #(
    parameter int unsigned TW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_inc,
    input  logic [TW-1:0] i_term,
    output logic          o_tc
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Next count: clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc) begin
            count_d = count_q + TW'(1);
        end
    end

    // Counter register, cleared by the asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_tc = (count_q == i_term);

endmodule

// File: rtl/clk_ratio_ctrl.sv
// Clock-ratio change controller, placed directly upstream of the divider.
// Accepts ratio requests over valid/ready, rejects illegal ones with a
// one-cycle o_err pulse, and applies legal changes as
// disable -> drain -> load -> settle -> re-enable, so ratio and enable
// never change in the same cycle.
// Build option: define CLK_RATIO_CLAMP_EN to clamp requests above
// MAX_RATIO instead of rejecting them. Ratio 0 is always rejected.
module clk_ratio_ctrl
    import clk_ratio_pkg::*;
#(
    parameter int unsigned RATIO_WD   = RATIO_WD_DEF,
    parameter int unsigned DEF_RATIO  = 1,
    parameter int unsigned MAX_RATIO  = 128,
    parameter int unsigned DRAIN_CYC  = 4,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                i_ref_clk,
    input  logic                i_rst_n,
    input  logic                i_req_valid,
    input  logic [RATIO_WD-1:0] i_req_ratio,
    output logic                o_req_ready,
    output logic [RATIO_WD-1:0] o_div_ratio,
    output logic                o_clk_en,
    output logic                o_busy,
    output logic                o_err
);

    localparam int unsigned TW = $clog2(max_u(DRAIN_CYC, SETTLE_CYC) + 1);
    localparam logic [TW-1:0]       DRAIN_TERM  = TW'(DRAIN_CYC - 1);
    localparam logic [TW-1:0]       SETTLE_TERM = TW'(SETTLE_CYC - 1);
    localparam logic [RATIO_WD-1:0] MAX_R       = RATIO_WD'(MAX_RATIO);
    localparam logic [RATIO_WD-1:0] DEF_R       = RATIO_WD'(DEF_RATIO);

    ratio_state_e        state_q, state_d;
    logic [RATIO_WD-1:0] ratio_q, ratio_d;
    logic [RATIO_WD-1:0] pend_q, pend_d;
    logic                en_q, en_d;
    logic                err_q, err_d;

    logic                accept;
    logic                req_err;
    logic [RATIO_WD-1:0] eff_ratio;
    logic                tmr_clr;
    logic                tmr_inc;
    logic [TW-1:0]       tmr_term;
    logic                tmr_tc;

    // Request validation: decide the effective ratio and whether it is illegal.
    always_comb begin
        accept = i_req_valid && (state_q == ST_IDLE);
`ifdef CLK_RATIO_CLAMP_EN
        eff_ratio = (i_req_ratio > MAX_R) ? MAX_R : i_req_ratio;
        req_err   = (i_req_ratio == '0);
`else
        eff_ratio = i_req_ratio;
        req_err   = (i_req_ratio == '0) || (i_req_ratio > MAX_R);
`endif
    end

    // Next-state logic for the change sequence and its registered outputs.
    always_comb begin
        state_d  = state_q;
        ratio_d  = ratio_q;
        pend_d   = pend_q;
        en_d     = en_q;
        err_d    = 1'b0;
        tmr_clr  = 1'b0;
        tmr_inc  = 1'b0;
        tmr_term = SETTLE_TERM;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        err_d = 1'b1;
                    end else if (eff_ratio != ratio_q) begin
                        pend_d  = eff_ratio;
                        en_d    = 1'b0;
                        tmr_clr = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                tmr_term = DRAIN_TERM;
                if (tmr_tc) begin
                    state_d = ST_LOAD;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_LOAD: begin
                ratio_d = pend_q;
                tmr_clr = 1'b1;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                tmr_term = SETTLE_TERM;
                if (tmr_tc) begin
                    en_d    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
        endcase
    end

    // State and output registers; reset re-enters SETTLE to rerun start-up.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_SETTLE;
            ratio_q <= DEF_R;
            pend_q  <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ratio_q <= ratio_d;
            pend_q  <= pend_d;
            en_q    <= en_d;
            err_q   <= err_d;
        end
    end

    clk_ratio_timer #(
        .TW (TW)
    ) u_timer (
        .i_clk   (i_ref_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (tmr_clr),
        .i_inc   (tmr_inc),
        .i_term  (tmr_term),
        .o_tc    (tmr_tc)
    );

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_busy      = !o_req_ready;
    assign o_div_ratio = ratio_q;
    assign o_clk_en    = en_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_clk_ratio_ctrl.sv
// Self-checking bench for clk_ratio_ctrl: a scripted vector table, hand
// sequences for back-to-back requests, reset mid-change and out-of-range
// requests, then randomized traffic against a countdown reference model.
module tb_clk_ratio_ctrl;

    localparam int RW     = 8;
    localparam int DEFR   = 1;
    localparam int MAXR   = 128;
    localparam int DRAIN  = 4;
    localparam int SETTLE = 2;
`ifdef CLK_RATIO_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic [RW-1:0] req_ratio;
    logic          req_ready;
    logic [RW-1:0] div_ratio;
    logic          clk_en;
    logic          busy;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a change is a fixed-length busy window with the
    // ratio landing a fixed number of edges into it.
    int m_ratio, m_en, m_err, m_busy_left, m_load_left, m_pending;

    typedef struct {
        logic        v;
        logic [7:0]  r;
        int          e_ratio;
        logic        e_en;
        logic        e_rdy;
        logic        e_err;
    } vec_t;
    vec_t vecs[14];

    clk_ratio_ctrl #(
        .RATIO_WD   (RW),
        .DEF_RATIO  (DEFR),
        .MAX_RATIO  (MAXR),
        .DRAIN_CYC  (DRAIN),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .i_ref_clk   (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_ratio (req_ratio),
        .o_req_ready (req_ready),
        .o_div_ratio (div_ratio),
        .o_clk_en    (clk_en),
        .o_busy      (busy),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ratio     = DEFR;
        m_en        = 0;
        m_err       = 0;
        m_busy_left = SETTLE;
        m_load_left = 0;
        m_pending   = 0;
    endtask

    task automatic model_step(input logic v, input int r);
        int eff;
        m_err = 0;
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_load_left > 0) begin
                m_load_left--;
                if (m_load_left == 0) m_ratio = m_pending;
            end
            if (m_busy_left == 0) m_en = 1;
        end else if (v) begin
            eff = (CLAMP && r > MAXR) ? MAXR : r;
            if (r == 0 || (!CLAMP && r > MAXR)) begin
                m_err = 1;
            end else if (eff != m_ratio) begin
                m_pending   = eff;
                m_en        = 0;
                m_busy_left = DRAIN + SETTLE + 1;
                m_load_left = DRAIN + 1;
            end
        end
    endtask

    task automatic check_outputs();
        check("div_ratio", int'(div_ratio), m_ratio);
        check("clk_en", int'(clk_en), m_en);
        check("req_ready", int'(req_ready), int'(m_busy_left == 0));
        check("busy", int'(busy), int'(m_busy_left != 0));
        check("err", int'(err), m_err);
    endtask

    task automatic drive_cycle(input logic v, input int r);
        req_valid = v;
        req_ratio = RW'(r);
        model_step(v, r);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 50) begin
            drive_cycle(1'b0, 0);
            n++;
        end
        check("reach_idle", int'(req_ready), 1);
    endtask

    initial begin
        // Scripted sequence right after reset release.
        vecs[0]  = '{1'b0, 8'd0, 1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'd0, 1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'd6, 1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'd0, 1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'd0, 1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'd0, 1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'd0, 1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'd0, 6, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'd0, 6, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'd0, 6, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 8'd6, 6, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 8'd0, 6, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 8'd0, 6, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 8'd1, 6, 1'b0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_ratio = '0;
        #12;
        check("rst_ratio", int'(div_ratio), DEFR);
        check("rst_clk_en", int'(clk_en), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_ready", int'(req_ready), 0);
        check("rst_err", int'(err), 0);
        m_reset();
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive_cycle(vecs[i].v, int'(vecs[i].r));
            check($sformatf("vec%0d_ratio", i), int'(div_ratio), vecs[i].e_ratio);
            check($sformatf("vec%0d_en", i), int'(clk_en), int'(vecs[i].e_en));
            check($sformatf("vec%0d_ready", i), int'(req_ready), int'(vecs[i].e_rdy));
            check($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].e_err));
        end
        wait_idle();
        check("after_table_ratio", int'(div_ratio), 1);

        // Second request held valid through an in-flight change.
        drive_cycle(1'b1, 6);
        for (int e = 1; e <= 8; e++) begin
            drive_cycle(1'b1, 3);
            if (e == 7) begin
                check("b2b_e7_ready", int'(req_ready), 1);
                check("b2b_e7_ratio", int'(div_ratio), 6);
            end
            if (e == 8) begin
                check("b2b_e8_en", int'(clk_en), 0);
                check("b2b_e8_ready", int'(req_ready), 0);
            end
        end
        drive_cycle(1'b0, 0);
        wait_idle();
        check("b2b_final_ratio", int'(div_ratio), 3);

        // Reset asserted during DRAIN of a 6-from-2 change.
        drive_cycle(1'b1, 2);
        wait_idle();
        drive_cycle(1'b1, 6);
        drive_cycle(1'b0, 0);
        drive_cycle(1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ratio", int'(div_ratio), DEFR);
        check("midrst_clk_en", int'(clk_en), 0);
        check("midrst_busy", int'(busy), 1);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) drive_cycle(1'b0, 0);
        check("midrst_final_ratio", int'(div_ratio), DEFR);
        check("midrst_final_en", int'(clk_en), 1);

        // Out-of-range request.
        drive_cycle(1'b1, 200);
`ifdef CLK_RATIO_CLAMP_EN
        check("over_err", int'(err), 0);
        check("over_en", int'(clk_en), 0);
        drive_cycle(1'b0, 0);
        wait_idle();
        check("over_clamped_ratio", int'(div_ratio), MAXR);
`else
        check("over_err", int'(err), 1);
        check("over_en", int'(clk_en), 1);
        check("over_ratio", int'(div_ratio), DEFR);
        drive_cycle(1'b0, 0);
        check("over_err_clear", int'(err), 0);
        wait_idle();
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            int r;
            case ($urandom_range(0, 6))
                0: r = 0;
                1: r = 1;
                2: r = MAXR;
                3: r = MAXR + 1 + int'($urandom_range(0, 255 - MAXR - 1));
                4: r = m_ratio;
                default: r = int'($urandom_range(1, MAXR));
            endcase
            drive_cycle(logic'($urandom_range(0, 1)), r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
